// File: rtl/bram_stream_reader_pkg.sv
// Shared constants for the BRAM burst reader: default sizes, FSM encoding
// and the address-width helper.
package bram_stream_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DATA_DEPTH = 256;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Counts significant bits of depth, so a power-of-two depth gets one spare
  // bit (256 -> 9).
  function automatic int clogb2(input int depth);
    int d;
    int n;
    d = depth;
    n = 0;
    while (d > 0) begin
      d = d >> 1;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bram_stream_reader_skid_fifo.sv
// Two-entry output buffer with valid/ready on both sides; head entry is
// presented combinationally so it stays stable while the consumer stalls.
module stream_skid_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  push, pop;

  assign s_ready = (count_q != 2'd2);
  assign m_valid = (count_q != 2'd0);
  assign m_data  = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Burst reader: issues sequential BRAM reads (wrapping at DATA_DEPTH) and
// streams the words out through a 2-entry buffer with valid/ready flow control.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DATA_DEPTH = DEFAULT_DATA_DEPTH,
  localparam int ADDR_WIDTH = clogb2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;
  logic                  rd_last, pop, room, fifo_s_ready;
  logic [1:0]            fifo_count;
  logic [2:0]            occ_next;
  logic [DATA_WIDTH:0]   fifo_m_data;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(DATA_DEPTH - 1)) return '0;
    return a + 1'b1;
  endfunction

  assign pop      = m_valid && m_ready;
  // Occupancy after this edge if a word lands now; a new read is safe only
  // when its data will still find a free slot next cycle.
  assign occ_next = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign room     = fifo_s_ready && (occ_next < 3'd2);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    done_d          = 1'b0;
    rd_en           = 1'b0;
    rd_addr         = '0;
    rd_last         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            // First read goes out in the start cycle to reach the 2-cycle latency.
            rd_en   = 1'b1;
            rd_addr = base_addr;
            rd_last = (length == ADDR_WIDTH'(1));
            addr_d  = next_addr(base_addr);
            rem_d   = length - 1'b1;
            state_d = (length == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_READ;
          end
        end
      end
      ST_READ: begin
        if (room) begin
          rd_en   = 1'b1;
          rd_addr = addr_q;
          rd_last = (rem_q == ADDR_WIDTH'(1));
          addr_d  = next_addr(addr_q);
          rem_d   = rem_q - 1'b1;
          if (rem_q == ADDR_WIDTH'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && m_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d      = rd_en;
    inflight_last_d = rd_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  stream_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH + 1)
  ) u_out_buf (
    .clk    (clk),
    .rst    (rst),
    .s_valid(inflight_q),
    .s_ready(fifo_s_ready),
    .s_data ({inflight_last_q, rd_data}),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (fifo_m_data),
    .count  (fifo_count)
  );

  assign m_last = fifo_m_data[DATA_WIDTH];
  assign m_data = fifo_m_data[DATA_WIDTH-1:0];
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;

endmodule
